// File: rtl/sd_pkg.sv
// Shared types and defaults for the sequence-detector stream controller.
package sd_pkg;

  localparam int SD_WIDTH   = 10;
  localparam int SD_DET_LAT = 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    DONE
  } sd_state_t;

endpackage

// File: rtl/sd_shift_src.sv
// Loadable LSB-first shift source; drives the registered detector input bit.
module sd_shift_src
  import sd_pkg::*;
#(
  parameter int WIDTH = SD_WIDTH,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_run,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_sd,
  output logic [LEN_W-1:0] o_idx,
  output logic             o_last
);

  logic [WIDTH-1:0] r_sh;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_sd;

  assign o_sd   = r_sd;
  assign o_idx  = r_cnt;
  assign o_last = (r_cnt == r_len - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_sd  <= 1'b0;
    end else if (i_clr) begin
      r_sd <= 1'b0;
    end else if (i_load) begin
      r_sh  <= i_data >> 1;
      r_sd  <= i_data[0];
      r_cnt <= '0;
      r_len <= i_len;
    end else if (i_run && !o_last) begin
      r_sd  <= r_sh[0];
      r_sh  <= r_sh >> 1;
      r_cnt <= r_cnt + LEN_W'(1);
    end else begin
      // last bit leaves the line; detector sees zeros afterwards
      r_sd <= 1'b0;
    end
  end

endmodule

// File: rtl/sd_stream_ctrl.sv
// Streams a word into the sequence detector and tallies aligned hits.
module sd_stream_ctrl
  import sd_pkg::*;
#(
  parameter int WIDTH   = SD_WIDTH,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 4,
  parameter int DET_LAT = SD_DET_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic [LEN_W-1:0] first_idx,
  output logic             hit,
  output logic             sd_i,
  input  logic             sd_o
);

  sd_state_t r_state;
  sd_state_t w_next;

  logic             w_accept;
  logic             w_abort;
  logic             w_run;
  logic             w_last;
  logic             w_smp;
  logic [LEN_W-1:0] w_idx;
  logic [LEN_W-1:0] w_len;

  logic [DET_LAT-1:0] r_vld;
  logic [DET_LAT-1:0] r_lst;
  logic [LEN_W-1:0]   r_idx [DET_LAT];

  logic [CNT_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_fidx;
  logic             r_hit;

  assign ready = (r_state == IDLE);
  assign busy  = (r_state == SHIFT) || (r_state == DRAIN);
  assign done  = (r_state == DONE);

  assign match_count = r_cnt;
  assign first_idx   = r_fidx;
  assign hit         = r_hit;

  assign w_accept = start && (r_state == IDLE);
  assign w_abort  = abort && (r_state != IDLE);
  assign w_run    = (r_state == SHIFT);
  assign w_len    = (len_in == '0 || int'(len_in) > WIDTH)
                  ? LEN_W'(WIDTH) : len_in;

  sd_shift_src #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_src (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_run  (w_run),
    .i_clr  (w_abort),
    .i_data (data_in),
    .i_len  (w_len),
    .o_sd   (sd_i),
    .o_idx  (w_idx),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start) w_next = SHIFT;
      SHIFT: if (w_last) w_next = DRAIN;
      DRAIN: if (r_lst[DET_LAT-1]) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  // each tag reaches the tail as the detector reflects its bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_lst <= '0;
      for (int i = 0; i < DET_LAT; i++) r_idx[i] <= '0;
    end else if (w_abort || w_accept) begin
      r_vld <= '0;
      r_lst <= '0;
    end else begin
      r_vld[0] <= w_run;
      r_lst[0] <= w_run && w_last;
      r_idx[0] <= w_idx;
      for (int i = 1; i < DET_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_lst[i] <= r_lst[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  assign w_smp = r_vld[DET_LAT-1] && sd_o && !w_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_fidx <= '0;
      r_hit  <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_fidx <= '0;
      r_hit  <= 1'b0;
    end else if (w_smp) begin
      if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      if (!r_hit) begin
        r_hit  <= 1'b1;
        r_fidx <= r_idx[DET_LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_sd_stream_ctrl.sv
// Randomised bench for sd_stream_ctrl against a word-level reference model.
module tb_sd_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start2;
  logic [9:0] data_in;
  logic [3:0] len_in;
  logic       abort;
  logic       force2;

  logic       ready, busy, done, hit, sd_i, sd_o;
  logic [3:0] match_count, first_idx;
  logic       ready2, busy2, done2, hit2, sd_i2, sd_o2;
  logic [1:0] match_count2;
  logic [3:0] first_idx2;

  logic [3:0] h1 = '0;
  logic [3:0] h2 = '0;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  // reference detector: Moore, one cycle latency, oldest-first 1,0,1,1
  always @(posedge clk) h1 <= {h1[2:0], sd_i};
  always @(posedge clk) h2 <= {h2[2:0], sd_i2};
  assign sd_o  = (h1 == 4'b1011);
  assign sd_o2 = force2 ? 1'b1 : (h2 == 4'b1011);

  sd_stream_ctrl #(
    .WIDTH(10), .LEN_W(4), .CNT_W(4), .DET_LAT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .data_in(data_in), .len_in(len_in), .abort(abort),
    .ready(ready), .busy(busy), .done(done),
    .match_count(match_count), .first_idx(first_idx),
    .hit(hit), .sd_i(sd_i), .sd_o(sd_o)
  );

  sd_stream_ctrl #(
    .WIDTH(10), .LEN_W(4), .CNT_W(2), .DET_LAT(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .data_in(data_in), .len_in(len_in), .abort(1'b0),
    .ready(ready2), .busy(busy2), .done(done2),
    .match_count(match_count2), .first_idx(first_idx2),
    .hit(hit2), .sd_i(sd_i2), .sd_o(sd_o2)
  );

  function automatic int eff_len(input logic [3:0] l);
    return (l == 0 || l > 10) ? 10 : int'(l);
  endfunction

  // word-level model: slide a 4-bit window over the streamed bits
  function automatic void model(input logic [9:0] d, input int n,
                                input int sat, input bit all,
                                output int cnt, output int fi,
                                output bit h);
    cnt = 0; fi = 0; h = 0;
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      for (int j = 3; j >= 0; j--)
        w = w * 2 + ((k - j >= 0) ? int'(d[k-j]) : 0);
      if (all || w == 11) begin
        if (cnt < sat) cnt++;
        if (!h) begin h = 1; fi = k; end
      end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; start2 = 0; abort = 0; force2 = 0;
    data_in = '0; len_in = '0;
    #12;
    total++;
    if ({ready, busy, done, sd_i, match_count, first_idx, hit}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0})
      $display("FAIL reset: got r%b b%b d%b s%b c%0d f%0d h%b",
               ready, busy, done, sd_i, match_count, first_idx, hit);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic check_run(input string nm, input logic [9:0] d,
                           input logic [3:0] l, input bit spam);
    int n, ecnt, efi, nd, dc;
    bit eh;
    logic [9:0] got;
    logic       drain_sd;
    n = eff_len(l);
    model(d, n, 15, 0, ecnt, efi, eh);
    nd = 0; dc = -1; got = '0; drain_sd = 1'b0;
    @(posedge clk); #1;
    data_in = d; len_in = l; start = 1;
    @(posedge clk); #1;
    start = spam;
    data_in = 10'($urandom); len_in = 4'($urandom);
    for (int c = 1; c <= n + 6; c++) begin
      @(negedge clk);
      if (c <= n) got[c-1] = sd_i;
      if (c == n + 1) drain_sd = sd_i;
      if (c == 1) begin
        total++;
        if (busy !== 1'b1 || ready !== 1'b0)
          $display("FAIL %s busy: got b%b r%b expected b1 r0",
                   nm, busy, ready);
        else pass_cnt++;
      end
      if (done) begin
        nd++;
        if (dc < 0) dc = c;
        start = 0;
      end
    end
    start = 0;
    for (int k = n; k < 10; k++) got[k] = d[k];
    total++;
    if (got !== d || drain_sd !== 1'b0)
      $display("FAIL %s bits: got %b/%b expected %b/0",
               nm, got, drain_sd, d);
    else pass_cnt++;
    chk({nm, " ndone"}, nd, 1);
    chk({nm, " done_cyc"}, dc, n + 2);
    chk({nm, " count"}, int'(match_count), ecnt);
    chk({nm, " first"}, int'(first_idx), efi);
    chk({nm, " hit"}, int'(hit), int'(eh));
    chk({nm, " ready"}, int'(ready), 1);
  endtask

  task automatic test_run1;
    check_run("run1", 10'b0001101011, 4'd10, 0);
    chk("run1 spec_count", int'(match_count), 1);
    chk("run1 spec_first", int'(first_idx), 6);
  endtask

  task automatic test_run2;
    check_run("run2", 10'h06D, 4'd7, 0);
    chk("run2 spec_count", int'(match_count), 2);
    chk("run2 spec_first", int'(first_idx), 3);
  endtask

  task automatic test_len0_spam;
    check_run("run3", 10'h000, 4'd0, 1);
  endtask

  task automatic test_abort;
    int nd;
    nd = 0;
    @(posedge clk); #1;
    data_in = 10'b0001101011; len_in = 4'd10; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1;
    abort = 0;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || sd_i !== 1'b0)
      $display("FAIL abort: got r%b b%b s%b expected r1 b0 s0",
               ready, busy, sd_i);
    else pass_cnt++;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort nodone", nd, 0);
    check_run("run4", 10'b0001101011, 4'd10, 0);
  endtask

  task automatic test_async_reset;
    int nd;
    nd = 0;
    @(posedge clk); #1;
    data_in = 10'b0001101011; len_in = 4'd10; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (8) @(posedge clk);
    #2;
    chk("arst pre_count", int'(match_count), 1);
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || sd_i !== 1'b0 || match_count !== 4'd0 ||
        ready !== 1'b1 || hit !== 1'b0)
      $display("FAIL arst: got b%b s%b c%0d r%b h%b expected b0 s0 c0 r1 h0",
               busy, sd_i, match_count, ready, hit);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("arst nodone", nd, 0);
  endtask

  task automatic run2(input string nm, input logic [9:0] d,
                      input bit all);
    int ecnt, efi, dc;
    bit eh;
    model(d, 10, 3, all, ecnt, efi, eh);
    dc = -1;
    @(posedge clk); #1;
    force2 = all; data_in = d; len_in = 4'd10; start2 = 1;
    @(posedge clk); #1;
    start2 = 0;
    for (int c = 1; c <= 20 && dc < 0; c++) begin
      @(negedge clk);
      if (done2) dc = c;
    end
    chk({nm, " done_cyc"}, dc, 12);
    chk({nm, " count"}, int'(match_count2), ecnt);
    chk({nm, " first"}, int'(first_idx2), efi);
    chk({nm, " hit"}, int'(hit2), int'(eh));
    force2 = 0;
  endtask

  task automatic test_saturate;
    run2("sat_det", 10'h36D, 0);
    chk("sat_det spec_count", int'(match_count2), 3);
    run2("sat_force", 10'($urandom), 1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      logic [9:0] d;
      logic [3:0] l;
      d = 10'($urandom);
      l = 4'($urandom_range(0, 15));
      check_run($sformatf("rnd%0d", i), d, l, 0);
    end
  endtask

  initial begin
    test_reset;
    test_run1;
    test_run2;
    test_len0_spam;
    test_abort;
    test_async_reset;
    test_saturate;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/sd_stream_ctrl.md
Name: sd_stream_ctrl

Overview:
Sequencer that drives the single-bit sequence detector (SD) from a parallel word and collects its results. Accepts a word and a bit length through a start/ready handshake. Shifts the bits LSB-first onto the detector input, one per clock, then counts the detector `o` pulses that are aligned to the shifted bits. Reports the match count, the index of the first match and a one-cycle done pulse, so software/top-level logic can run detection on words instead of hand-generated bit streams.

Parameters:
WIDTH, 10, maximum word length in bits
LEN_W, 4, width of len_in (must satisfy 2^LEN_W > WIDTH)
CNT_W, 4, width of match_count (saturating)
DET_LAT, 1, cycles from a bit being presented on sd_i to the detector's o reflecting it (1..4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a run; accepted only when ready=1
data_in  in  WIDTH  word to stream, bit 0 first
len_in  in  LEN_W  bits to stream; 0 or >WIDTH treated as WIDTH
abort  in  1  cancel current run
ready  out  1  controller idle, start will be accepted
busy  out  1  run in progress (SHIFT or DRAIN)
done  out  1  one-cycle pulse at run completion
match_count  out  CNT_W  detector hits in last run, saturating
first_idx  out  LEN_W  bit index whose arrival caused first hit
hit  out  1  at least one hit in last run
sd_i  out  1  registered bit to detector input i
sd_o  in  1  detector output o

Behaviour:
- One clock domain; reset is asynchronous and active-low. All state is clocked on the rising edge of clk, and rst_n=0 clears it immediately.
- Reset values: state=IDLE, ready=1, busy=0, done=0, sd_i=0, match_count=0, first_idx=0, hit=0.
- States: IDLE, SHIFT, DRAIN, DONE.
- IDLE:
  - ready=1.
  - start=1 at edge T: latch data_in into the shift register and the effective len into the length register, clear match_count/first_idx/hit, and go to SHIFT.
- SHIFT:
  - sd_i is registered; bit k is driven during cycle T+1+k, k=0..len-1.
  - Shift register shifts right each cycle and the bit counter increments.
  - After bit len-1, go to DRAIN.
- DRAIN:
  - sd_i=0.
  - Wait until every shifted bit's response window has been sampled.
- Sampling:
  - A DET_LAT-deep valid pipeline tags each shifted bit.
  - At each edge where the tagged bit k reaches the end of the pipeline (end of cycle T+1+k+DET_LAT) and sd_o=1, match_count increments. It saturates at 2^CNT_W-1.
  - On the first such hit in the run, first_idx=k and hit=1.
  - sd_o outside tagged windows is ignored.
- DONE:
  - done=1 for exactly one cycle, at cycle T+len+DET_LAT+1; for len=10 with DET_LAT=1, done is in cycle T+12.
  - Next state is IDLE.
  - Results hold until the next accepted start.
- sd_i=0 whenever not in SHIFT, so the detector sees idle zeros between runs.
- start while busy: ignored, no queuing.
- start and done in the same cycle: ignored, because ready=0 in DONE.
- abort (any non-IDLE state):
  - Go to IDLE next cycle and force sd_i=0.
  - No done pulse; partial match_count/hit/first_idx remain visible.
  - abort has priority over all transitions. abort in IDLE has no effect.
- rst_n asserted mid-run: all outputs return to reset values immediately; no done pulse.
- len=1: single bit, done at T+DET_LAT+2.

Decomposition:
- Shared package `sd_pkg`:
  - state enum (IDLE/SHIFT/DRAIN/DONE);
  - default constants `SD_WIDTH=10`, `SD_DET_LAT=1`.
- One natural sub-module, `sd_shift_src`: a loadable right-shift register with bit counter and last-bit flag, driving sd_i.
- Match counting and the FSM stay in the top.
- The detector itself is instantiated by the parent, not inside this block.

Test Plan:
- The bench connects a reference detector model: Moore, DET_LAT=1, o=1 when the last four bits received (oldest first) are 1,0,1,1.
- Run 1: reset, then start with data_in=10'b0001101011, len_in=10 -> sd_i sequence 1,1,0,1,0,1,1,0,0,0; done exactly 12 cycles after the start edge; match_count=1, first_idx=6, hit=1.
- Run 2: data_in=10'h06D, len_in=7 -> overlapping matches; match_count=2, first_idx=3, hit=1, done at T+9.
- Run 3: data_in=0, len_in=0 -> 10 bits streamed, match_count=0, hit=0; start pulsed every cycle during the run is ignored, exactly one done.
- Run 4: start a run, assert abort during bit 4 -> ready=1 the next cycle, sd_i=0, no done; a following start with data_in=10'b0001101011, len_in=10 yields the same results as Run 1.
- Run 5: drop rst_n asynchronously mid-SHIFT (between clock edges) -> busy=0, sd_i=0, match_count=0 immediately; no done. With CNT_W=2, stream 1011011011 -> match_count saturates at 3.
